// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - round timer and hit scorer for the target game
module game_ctrl #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int ROUND_SEC = 60,
  parameter int SCORE_MAX = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       hit,
  output logic [5:0] cnttime,
  output logic [4:0] score,
  output logic       running,
  output logic       game_over,
  output logic       tick
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [5:0]    SEC_INIT   = 6'(ROUND_SEC);
  localparam logic [4:0]    SCORE_TOP  = 5'(SCORE_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [5:0]    cnt_nxt;
  logic [4:0]    score_nxt;
  logic          tick_nxt;

  logic start_q, pause_q, hit_q;
  logic start_rise, pause_rise, hit_rise;
  logic sec_wrap;

  assign start_rise = start & ~start_q;
  assign pause_rise = pause & ~pause_q;
  assign hit_rise   = hit & ~hit_q;
  assign sec_wrap   = (presc == PRESC_LAST);

  assign running   = (state == S_RUN);
  assign game_over = (state == S_OVER);

  // Edge-detect history; preset high so a level held through reset is not a rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b1;
      pause_q <= 1'b1;
      hit_q   <= 1'b1;
    end else begin
      start_q <= start;
      pause_q <= pause;
      hit_q   <= hit;
    end
  end

  // State, prescaler, timer, score and tick registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      presc   <= '0;
      cnttime <= SEC_INIT;
      score   <= '0;
      tick    <= 1'b0;
    end else begin
      state   <= state_nxt;
      presc   <= presc_nxt;
      cnttime <= cnt_nxt;
      score   <= score_nxt;
      tick    <= tick_nxt;
    end
  end

  // Next-state logic: a start rise restarts the round from any state and wins
  // over everything; in RUN the final decrement wins over a pause request
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    cnt_nxt   = cnttime;
    score_nxt = score;
    tick_nxt  = 1'b0;

    if (start_rise) begin
      state_nxt = S_RUN;
      presc_nxt = '0;
      cnt_nxt   = SEC_INIT;
      score_nxt = '0;
    end else begin
      case (state)
        S_RUN: begin
          if (sec_wrap) begin
            presc_nxt = '0;
            cnt_nxt   = cnttime - 6'd1;
            tick_nxt  = 1'b1;
          end else begin
            presc_nxt = presc + 1'b1;
          end
          if (hit_rise && (score != SCORE_TOP)) begin
            score_nxt = score + 5'd1;
          end
          if (sec_wrap && (cnttime == 6'd1)) begin
            state_nxt = S_OVER;
          end else if (pause_rise) begin
            state_nxt = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (pause_rise) begin
            state_nxt = S_RUN;
          end
        end
        default: begin
          presc_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000: clk cycles per one-second tick; legal range >=2.
REQ-002 Parameter ROUND_SEC, default 60: round length in seconds; legal range 1..60.
REQ-003 Parameter SCORE_MAX, default 19: score saturation value; legal range 1..19.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  start/restart request, synchronous level; acted on at its rising edge.
REQ-007 pause  input  1  pause/resume toggle request, synchronous level; acted on at its rising edge.
REQ-008 hit  input  1  hit-detected level from the target logic; acted on at its rising edge.
REQ-009 cnttime  output  6  remaining seconds, binary, 0..ROUND_SEC; drives the display scanner.
REQ-010 score  output  5  hit count, binary, 0..SCORE_MAX; drives the display scanner.
REQ-011 running  output  1  high iff state is RUN.
REQ-012 game_over  output  1  high iff state is OVER.
REQ-013 tick  output  1  one-cycle pulse on each one-second decrement.

Function
REQ-014 Edge detect: one register each for start, pause and hit; rise = input high AND register low; registers update every cycle.
REQ-015 States: IDLE, RUN, PAUSE, OVER; 2-bit encoding; all outputs registered or decoded from registered state only.
REQ-016 Prescaler: counter of ceil(log2(TICK_DIV)) bits; counts 0..TICK_DIV-1 only in RUN; holds in PAUSE; cleared in IDLE and OVER.
REQ-017 IDLE: cnttime=ROUND_SEC, score=0; start rise -> RUN on the same edge, prescaler=0.
REQ-018 RUN, prescaler==TICK_DIV-1: on that edge prescaler<=0, cnttime<=cnttime-1, tick<=1; tick is therefore high in the cycle the new cnttime is visible.
REQ-019 RUN: the first tick occurs exactly TICK_DIV cycles after entry to RUN; subsequent ticks every TICK_DIV cycles.
REQ-020 RUN: a decrement that sets cnttime to 0 also sets state to OVER on the same edge.
REQ-021 RUN: hit rise -> score<=score+1; if score==SCORE_MAX, score holds (saturating; no wrap).
REQ-022 RUN: pause rise -> PAUSE; PAUSE: pause rise -> RUN, with the prescaler resuming from its held value.
REQ-023 PAUSE, IDLE, OVER: hit rises are ignored; tick=0.
REQ-024 OVER: cnttime=0, score held, game_over=1; start rise -> RUN with cnttime=ROUND_SEC, score=0, prescaler=0.
REQ-025 start rise in RUN or PAUSE: restart (cnttime=ROUND_SEC, score=0, prescaler=0, state RUN).
REQ-026 Priority within one cycle: start > tick/hit > pause.
REQ-027 start rise overrides any tick, hit or pause in the same cycle.
REQ-028 Hit rise coincident with the final tick: the hit is counted and the state goes to OVER.
REQ-029 Pause rise coincident with a tick: the decrement is applied and the state goes to PAUSE.
REQ-030 Pause rise coincident with the final tick: OVER wins.

Reset
REQ-031 rst high forces, immediately and asynchronously: state IDLE, cnttime=ROUND_SEC, score=0, prescaler=0, tick=0, running=0, game_over=0.
REQ-032 rst high sets all three edge registers to 1, so an input held high through reset release produces no rise.
REQ-033 rst asserted mid-round discards all round progress; no state is retained.

Verification (TICK_DIV=4, ROUND_SEC=3, SCORE_MAX=19)
REQ-034 Reset, then a 1-cycle start pulse -> running=1 from the next cycle; tick pulses at 4, 8 and 12 cycles after entry with cnttime 2, 1, 0; game_over=1 and running=0 at the 12th cycle.
REQ-035 25 hit rises spaced 2 cycles apart during RUN with TICK_DIV=1000 -> score reaches 19 and holds at 19.
REQ-036 Pause rise 6 cycles after RUN entry (cnttime=2), held in PAUSE for 20 cycles, then a pause rise -> cnttime stays 2 throughout the pause; the next tick comes 2 cycles after resume.
REQ-037 Hit rise in the same cycle as the final tick with score=5 -> score=6, cnttime=0, state OVER.
REQ-038 Async rst pulse mid-RUN with cnttime=1 and score=7 -> cnttime=3, score=0, running=0 before the next clk edge.
REQ-039 start held high through rst release -> stays IDLE.
REQ-040 A subsequent start rise in OVER -> RUN with cnttime=3 and score=0.
